// File: rtl/ex_pkg.sv
// Shared definitions for the ID/EX operand stage: op encodings, default widths
// and the registered operand bundle handed to the EX adder/subtractor.
package ex_pkg;

    localparam int EX_DATA_W = 32;
    localparam int EX_REG_AW = 5;
    localparam int EX_IMM_W  = 16;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_SLT   = 2'd2,
        ALU_PASSB = 2'd3
    } alu_op_e;

    typedef struct packed {
        logic [EX_DATA_W-1:0] a;
        logic [EX_DATA_W-1:0] b;
        logic                 add_sub;
        logic                 slt;
        logic                 passb;
        logic [EX_REG_AW-1:0] rd;
        logic                 wr_en;
    } operand_t;

endpackage

// File: rtl/ex_fwd_mux.sv
// Operand source select: EX/MEM over MEM/WB over register file, r0 never forwarded.
// Purely combinational; with FORWARDING_EN undefined it passes register-file data.
module ex_fwd_mux
    import ex_pkg::*;
#(
    parameter int DATA_W = EX_DATA_W,
    parameter int REG_AW = EX_REG_AW
) (
    input  logic [REG_AW-1:0] i_addr,
    input  logic [DATA_W-1:0] i_rf_data,
    input  logic              i_exmem_wr,
    input  logic [REG_AW-1:0] i_exmem_rd,
    input  logic [DATA_W-1:0] i_exmem_data,
    input  logic              i_memwb_wr,
    input  logic [REG_AW-1:0] i_memwb_rd,
    input  logic [DATA_W-1:0] i_memwb_data,
    output logic [DATA_W-1:0] o_data
);

`ifdef FORWARDING_EN
    always_comb begin
        o_data = i_rf_data;
        if (i_exmem_wr && (i_exmem_rd == i_addr) && (i_addr != '0)) begin
            o_data = i_exmem_data;
        end else if (i_memwb_wr && (i_memwb_rd == i_addr) && (i_addr != '0)) begin
            o_data = i_memwb_data;
        end
    end
`else
    // Hazards are resolved by upstream stalls in this build.
    logic w_unused;
    assign w_unused = ^{i_addr, i_exmem_wr, i_exmem_rd, i_exmem_data,
                        i_memwb_wr, i_memwb_rd, i_memwb_data};
    assign o_data   = i_rf_data;
`endif

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register: forwards and extends operands, decodes add/sub control, 1-cycle latency.
// Single-entry valid/ready slot with flush; forwarding enabled by macro FORWARDING_EN.
module ex_operand_stage
    import ex_pkg::*;
#(
    parameter int DATA_W = EX_DATA_W,
    parameter int REG_AW = EX_REG_AW,
    parameter int IMM_W  = EX_IMM_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rs_addr,
    input  logic [REG_AW-1:0] in_rt_addr,
    input  logic [REG_AW-1:0] in_rd_addr,
    input  logic [DATA_W-1:0] in_rs_data,
    input  logic [DATA_W-1:0] in_rt_data,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic              in_use_imm,
    input  logic              in_sign_ext,
    input  logic [1:0]        in_alu_op,
    input  logic              in_wr_en,
    input  logic              exmem_wr,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_data,
    input  logic              memwb_wr,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              add_sub,
    output logic              out_slt,
    output logic              out_passb,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_wr_en
);

    logic              r_valid;
    operand_t          r_op;
    operand_t          w_next;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_rt;
    logic [DATA_W-1:0] w_imm_ext;
    logic              w_accept;
    alu_op_e           w_op;

    ex_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
        .i_addr       (in_rs_addr),
        .i_rf_data    (in_rs_data),
        .i_exmem_wr   (exmem_wr),
        .i_exmem_rd   (exmem_rd),
        .i_exmem_data (exmem_data),
        .i_memwb_wr   (memwb_wr),
        .i_memwb_rd   (memwb_rd),
        .i_memwb_data (memwb_data),
        .o_data       (w_a)
    );

    ex_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
        .i_addr       (in_rt_addr),
        .i_rf_data    (in_rt_data),
        .i_exmem_wr   (exmem_wr),
        .i_exmem_rd   (exmem_rd),
        .i_exmem_data (exmem_data),
        .i_memwb_wr   (memwb_wr),
        .i_memwb_rd   (memwb_rd),
        .i_memwb_data (memwb_data),
        .o_data       (w_rt)
    );

    assign in_ready  = !r_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_op      = alu_op_e'(in_alu_op);
    assign w_imm_ext = {{(DATA_W-IMM_W){in_sign_ext & in_imm[IMM_W-1]}}, in_imm};

    always_comb begin
        w_next         = '0;
        w_next.a       = w_a;
        w_next.b       = in_use_imm ? w_imm_ext : w_rt;
        w_next.add_sub = (w_op == ALU_SUB) || (w_op == ALU_SLT);
        w_next.slt     = (w_op == ALU_SLT);
        w_next.passb   = (w_op == ALU_PASSB);
        w_next.rd      = in_rd_addr;
        w_next.wr_en   = in_wr_en;
    end

    // Flush and bubbles clear only valid/wr_en; data fields stay at their last defined value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_op    <= '0;
        end else if (flush) begin
            r_valid    <= 1'b0;
            r_op.wr_en <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_op    <= w_next;
        end else if (out_ready) begin
            r_valid    <= 1'b0;
            r_op.wr_en <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign op_a      = r_op.a;
    assign op_b      = r_op.b;
    assign add_sub   = r_op.add_sub;
    assign out_slt   = r_op.slt;
    assign out_passb = r_op.passb;
    assign out_rd    = r_op.rd;
    assign out_wr_en = r_op.wr_en;

endmodule
